// File: rtl/sram_phase_seq.sv
// SRAM access phase sequencer: precharge -> wordline -> sense (reads) -> done.
// Each phase length is a programmable cycle count. One shared up-counter is
// cleared at every phase boundary. A zero length field is treated as one cycle.
module sram_phase_seq #(
    parameter int unsigned WIDTH = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [WIDTH-1:0] pre_len,
    input  logic [WIDTH-1:0] wl_len,
    input  logic [WIDTH-1:0] sae_len,
    output logic             pc_en,
    output logic             wl_en,
    output logic             wr_en,
    output logic             sae_en,
    output logic             done,
    output logic [WIDTH-1:0] phase_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_WL,
        S_SAE,
        S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] pre_q, pre_d;
    logic [WIDTH-1:0] wl_q, wl_d;
    logic [WIDTH-1:0] sae_q, sae_d;
    logic             we_q, we_d;
    logic [WIDTH-1:0] last_cnt;

    // Final counter value of a phase; a zero field behaves as a length of one.
    function automatic logic [WIDTH-1:0] last_idx(input logic [WIDTH-1:0] f);
        return (f == '0) ? '0 : f - WIDTH'(1);
    endfunction

    // State, counter and captured request fields; async reset returns to idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            pre_q   <= '0;
            wl_q    <= '0;
            sae_q   <= '0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pre_q   <= pre_d;
            wl_q    <= wl_d;
            sae_q   <= sae_d;
            we_q    <= we_d;
        end
    end

    // Next state: accept in idle, advance each phase when its counter hits L-1.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pre_d    = pre_q;
        wl_d     = wl_q;
        sae_d    = sae_q;
        we_d     = we_q;
        last_cnt = '0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (req_valid) begin
                    pre_d   = pre_len;
                    wl_d    = wl_len;
                    sae_d   = sae_len;
                    we_d    = req_we;
                    state_d = S_PRE;
                end
            end
            S_PRE: begin
                last_cnt = last_idx(pre_q);
                if (cnt_q == last_cnt) begin
                    cnt_d   = '0;
                    state_d = S_WL;
                end else begin
                    cnt_d = cnt_q + WIDTH'(1);
                end
            end
            S_WL: begin
                last_cnt = last_idx(wl_q);
                if (cnt_q == last_cnt) begin
                    cnt_d   = '0;
                    state_d = we_q ? S_DONE : S_SAE;
                end else begin
                    cnt_d = cnt_q + WIDTH'(1);
                end
            end
            S_SAE: begin
                last_cnt = last_idx(sae_q);
                if (cnt_q == last_cnt) begin
                    cnt_d   = '0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + WIDTH'(1);
                end
            end
            S_DONE: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs decoded from registered state only, so reset clears them at once.
    always_comb begin
        req_ready = 1'b0;
        pc_en     = 1'b0;
        wl_en     = 1'b0;
        wr_en     = 1'b0;
        sae_en    = 1'b0;
        done      = 1'b0;
        case (state_q)
            S_IDLE: req_ready = 1'b1;
            S_PRE:  pc_en = 1'b1;
            S_WL: begin
                wl_en = 1'b1;
                wr_en = we_q;
            end
            S_SAE: begin
                wl_en  = 1'b1;
                sae_en = 1'b1;
            end
            S_DONE: done = 1'b1;
            default: req_ready = 1'b0;
        endcase
    end

    assign phase_cnt = cnt_q;

endmodule

// File: tb/tb_sram_phase_seq.sv
// Bench for sram_phase_seq: schedule-based reference model compared every
// cycle, mutual-exclusion invariants, and directed pulse-count/latency checks.
module tb_sram_phase_seq;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [11:0] pre_len;
    logic [11:0] wl_len;
    logic [11:0] sae_len;
    logic        pc_en;
    logic        wl_en;
    logic        wr_en;
    logic        sae_en;
    logic        done;
    logic [11:0] phase_cnt;

    sram_phase_seq #(.WIDTH(12)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .pre_len   (pre_len),
        .wl_len    (wl_len),
        .sae_len   (sae_len),
        .pc_en     (pc_en),
        .wl_en     (wl_en),
        .wr_en     (wr_en),
        .sae_en    (sae_en),
        .done      (done),
        .phase_cnt (phase_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        ready;
        logic        pc;
        logic        wl;
        logic        wr;
        logic        sae;
        logic        dn;
        logic [11:0] cnt;
    } exp_t;

    localparam exp_t IDLE_E = '{ready: 1'b1, pc: 1'b0, wl: 1'b0, wr: 1'b0,
                                sae: 1'b0, dn: 1'b0, cnt: 12'd0};

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    exp_t cur   = IDLE_E;
    exp_t sched[$];
    int   acc_q[$];
    int   done_q[$];
    int   pc_n, wl_n, wr_n, sae_n, done_n;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic pc, input logic wl, input logic wr,
                                input logic sae, input logic dn, input int c);
        exp_t e;
        e.ready = 1'b0;
        e.pc    = pc;
        e.wl    = wl;
        e.wr    = wr;
        e.sae   = sae;
        e.dn    = dn;
        e.cnt   = 12'(c);
        return e;
    endfunction

    function automatic int eff(input logic [11:0] f);
        return (f == 12'd0) ? 1 : int'(f);
    endfunction

    // Reference model: on accept, lay out the whole access as a list of
    // per-cycle output vectors; each edge consumes one, idle when empty.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sched.delete();
            cur = IDLE_E;
        end else begin
            cyc++;
            if (cur.ready && req_valid) begin
                acc_q.push_back(cyc);
                for (int i = 0; i < eff(pre_len); i++)
                    sched.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, i));
                for (int i = 0; i < eff(wl_len); i++)
                    sched.push_back(mk(1'b0, 1'b1, req_we, 1'b0, 1'b0, i));
                if (!req_we)
                    for (int i = 0; i < eff(sae_len); i++)
                        sched.push_back(mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, i));
                sched.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0));
            end
            if (sched.size() > 0) cur = sched.pop_front();
            else cur = IDLE_E;
        end
    end

    // Per-cycle compare against the model, invariants, and pulse monitors.
    always @(negedge clk) begin
        exp_t act;
        act = '{ready: req_ready, pc: pc_en, wl: wl_en, wr: wr_en,
                sae: sae_en, dn: done, cnt: phase_cnt};
        total++;
        if (act !== cur) begin
            bad++;
            $display("FAIL cycle@%0d: got rdy/pc/wl/wr/sae/done/cnt=%b%b%b%b%b%b/%0d want %b%b%b%b%b%b/%0d",
                     cyc, act.ready, act.pc, act.wl, act.wr, act.sae, act.dn, act.cnt,
                     cur.ready, cur.pc, cur.wl, cur.wr, cur.sae, cur.dn, cur.cnt);
        end
        chk("inv_pc_wl", int'(pc_en && wl_en), 0);
        chk("inv_sae", int'(sae_en && !(wl_en && !wr_en)), 0);
        chk("inv_wr", int'(wr_en && !wl_en), 0);
        chk("inv_onehot", int'($countones({pc_en, wl_en, done}) > 1), 0);
        if (pc_en)  pc_n++;
        if (wl_en)  wl_n++;
        if (wr_en)  wr_n++;
        if (sae_en) sae_n++;
        if (done) begin
            done_n++;
            done_q.push_back(cyc);
        end
    end

    task automatic clear_mon();
        pc_n = 0; wl_n = 0; wr_n = 0; sae_n = 0; done_n = 0;
        acc_q.delete();
        done_q.delete();
    endtask

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_ready_wait"}, int'(req_ready), 1);
    endtask

    task automatic wait_done(input string name, input int want);
        int n;
        n = 0;
        while (done_n < want && n < 6000) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk({name, "_done_seen"}, done_n, want);
    endtask

    task automatic do_access(input string name, input logic we, input int p,
                             input int w, input int s, input int e_pc,
                             input int e_wl, input int e_wr, input int e_sae,
                             input int e_lat);
        @(negedge clk);
        wait_ready(name);
        clear_mon();
        req_we    = we;
        pre_len   = 12'(p);
        wl_len    = 12'(w);
        sae_len   = 12'(s);
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        wait_done(name, 1);
        @(negedge clk);
        #1;
        chk({name, "_pc_cycles"}, pc_n, e_pc);
        chk({name, "_wl_cycles"}, wl_n, e_wl);
        chk({name, "_wr_cycles"}, wr_n, e_wr);
        chk({name, "_sae_cycles"}, sae_n, e_sae);
        chk({name, "_done_pulses"}, done_n, 1);
        if (acc_q.size() == 1 && done_q.size() == 1)
            chk({name, "_latency"}, done_q[0] - acc_q[0], e_lat);
        else
            chk({name, "_accept_count"}, acc_q.size(), 1);
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        pre_len   = '0;
        wl_len    = '0;
        sae_len   = '0;
        clear_mon();

        // Reset held, then idle with no request.
        repeat (5) begin
            @(negedge clk);
            chk("rst_ready", int'(req_ready), 1);
            chk("rst_outs", int'({pc_en, wl_en, wr_en, sae_en, done}), 0);
            chk("rst_cnt", int'(phase_cnt), 0);
        end
        rst_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            chk("idle_ready", int'(req_ready), 1);
            chk("idle_outs", int'({pc_en, wl_en, wr_en, sae_en, done}), 0);
            chk("idle_cnt", int'(phase_cnt), 0);
        end

        do_access("rd_2_3_4", 1'b0, 2, 3, 4, 2, 7, 0, 4, 9);
        do_access("wr_1_5_7", 1'b1, 1, 5, 7, 1, 5, 5, 0, 6);
        do_access("rd_zero",  1'b0, 0, 0, 0, 1, 2, 0, 1, 3);
        do_access("wr_max",   1'b1, 4095, 1, 0, 4095, 1, 1, 0, 4096);

        // Back-to-back with req_valid held and fields changed mid-access.
        @(negedge clk);
        wait_ready("b2b");
        clear_mon();
        req_we    = 1'b0;
        pre_len   = 12'd2;
        wl_len    = 12'd2;
        sae_len   = 12'd2;
        req_valid = 1'b1;
        repeat (3) @(negedge clk);
        req_we    = 1'b1;
        pre_len   = 12'd3;
        wl_len    = 12'd4;
        sae_len   = 12'd0;
        wait_done("b2b", 2);
        req_valid = 1'b0;
        @(negedge clk);
        #1;
        if (acc_q.size() == 2 && done_q.size() == 2) begin
            chk("b2b_lat1", done_q[0] - acc_q[0], 6);
            chk("b2b_gap", acc_q[1] - done_q[0], 2);
            chk("b2b_lat2", done_q[1] - acc_q[1], 7);
        end else begin
            chk("b2b_accepts", acc_q.size(), 2);
        end
        chk("b2b_pc", pc_n, 5);
        chk("b2b_wr", wr_n, 4);
        chk("b2b_sae", sae_n, 2);

        // Reset in the middle of a long wordline phase.
        @(negedge clk);
        wait_ready("mid");
        clear_mon();
        req_we    = 1'b0;
        pre_len   = 12'd1;
        wl_len    = 12'd10;
        sae_len   = 12'd1;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("mid_wl_before", int'(wl_en), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_wl_async", int'(wl_en), 0);
        chk("mid_outs_async", int'({pc_en, wr_en, sae_en, done}), 0);
        chk("mid_ready_async", int'(req_ready), 1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        #1;
        chk("mid_no_done", done_n, 0);
        chk("mid_ready_after", int'(req_ready), 1);
        do_access("rd_after_rst", 1'b0, 3, 1, 1, 3, 2, 0, 1, 5);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sram_phase_seq.md
Name: sram_phase_seq

Overview:
- Cycle-accurate timing sequencer for one SRAM access: precharge, then wordline, then sense-amp enable (reads only), then a completion pulse.
- Each phase length is a programmable cycle count, timed by one internal WIDTH-bit up-counter that is cleared and re-enabled per phase.
- Sits between the host request interface and the bitcell-array control drivers; it replaces fixed delay chains during bring-up and characterisation.

Parameters:
- WIDTH, 12, width of the phase counter and of each phase-length field.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  1  access request.
- req_ready  out  1  sequencer idle; a request is accepted when req_valid && req_ready at a rising edge.
- req_we  in  1  1 = write access, 0 = read access; captured on accept.
- pre_len  in  WIDTH  precharge phase length in cycles; captured on accept.
- wl_len  in  WIDTH  wordline phase length in cycles; captured on accept.
- sae_len  in  WIDTH  sense phase length in cycles; captured on accept.
- pc_en  out  1  precharge enable.
- wl_en  out  1  wordline enable.
- wr_en  out  1  write-driver enable.
- sae_en  out  1  sense-amp enable.
- done  out  1  single-cycle completion pulse.
- phase_cnt  out  WIDTH  current counter value (debug).

Behaviour:
- All outputs are registered or decoded from registered state. No combinational path from any input to any output, except that req_ready depends only on state.
- States: IDLE, PRE, WL, SAE, DONE.
- Reset (rst_n low, any time, including mid-access):
  - state = IDLE.
  - phase_cnt = 0.
  - captured fields = 0.
  - pc_en = wl_en = wr_en = sae_en = done = 0.
  - req_ready = 1.
- Mid-access reset drops all enables immediately (asynchronously). There is no resume; the next access starts from IDLE.
- IDLE:
  - req_ready = 1; all enables 0.
  - On accept: latch req_we and the three lengths, clear phase_cnt, go to PRE.
  - Length fields are ignored while not in IDLE.
- Effective length of each phase:
  - L = field when field != 0.
  - L = 1 when field == 0 (zero-length phases are forbidden).
- Phase timing:
  - Each of PRE, WL and SAE lasts exactly L cycles.
  - phase_cnt counts 0..L-1 inside the phase.
  - When phase_cnt == L-1, the next edge moves to the next state and clears phase_cnt to 0.
  - The counter never wraps; the max value 2^WIDTH-1 gives a phase of 2^WIDTH-1 cycles.
- PRE:
  - pc_en = 1.
  - Next state: WL.
- WL:
  - wl_en = 1; wr_en = latched we.
  - Next state: SAE for a read, DONE for a write.
- SAE (reads only):
  - wl_en = 1 and sae_en = 1.
  - Next state: DONE.
- DONE:
  - done = 1 for exactly one cycle; all enables 0; req_ready = 0.
  - Next state: IDLE.
- Latency for an accept at edge E:
  - pc_en is high in the cycles after edges E .. E+P-1.
  - Total for a read, from accept to done: P+W+S cycles, with done high during the following cycle.
  - Write: same, with S omitted.
- Back-to-back: a request held high during DONE is accepted on the edge after DONE returns to IDLE. Minimum access spacing is P+W(+S)+2 cycles.
- Mutual exclusion invariants, checked every cycle:
  - pc_en is never high together with wl_en.
  - sae_en implies wl_en && !wr_en.
  - wr_en implies wl_en.
  - At most one of pc_en, wl_en, done is high.
- phase_cnt is 0 in IDLE and DONE.

Test Plan:
- Reset then idle:
  - Stimulus: hold rst_n=0 for 5 cycles, release, no request for 10 cycles.
  - Required: req_ready=1, all enables 0, phase_cnt=0 throughout.
- Read, pre=2, wl=3, sae=4:
  - Required: pc_en high for 2 cycles, then wl_en high for 7 cycles, with sae_en high in the last 4 of them.
  - Required: done pulses once, 9 cycles after accept; wr_en stays 0.
- Write, pre=1, wl=5, sae=7:
  - Required: pc_en for 1 cycle, then wl_en and wr_en for 5 cycles.
  - Required: sae_en never asserts; done 6 cycles after accept.
- Zero lengths, read, all fields 0:
  - Required: each phase lasts 1 cycle; done 3 cycles after accept.
- Back-to-back with field changes:
  - Stimulus: hold req_valid=1 continuously; change the length inputs mid-access.
  - Required: the in-flight access uses its latched values; the second accept occurs 1 cycle after done.
  - Required: the mutual-exclusion assertions hold throughout.
- Reset mid-access:
  - Stimulus: assert rst_n=0 during WL of a read with wl=10.
  - Required: wl_en drops without waiting for a clock edge; no done pulse.
  - Required: after release, req_ready=1; a new read with pre=3 gives pc_en for exactly 3 cycles.
